// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory port and instruction stream bundle for instr_fetch_unit
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [6:0]        opcode;
    logic [ADDR_W-1:0] instr_pc;
    logic              misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  stall, branch_taken, branch_target,
        output instr_valid, instr, opcode, instr_pc, misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output stall, branch_taken, branch_target,
        input  instr_valid, instr, opcode, instr_pc, misalign_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, single-outstanding imem fetch, instruction FIFO, branch redirect (IFU_MISALIGN_CHECK_EN)
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next, addr_q, tgt;
    logic [31:0]       buf_instr [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              redirect, push, pop, head_valid;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q;

    // A misaligned target is reported and otherwise treated as if no branch occurred.
    assign redirect = bus.branch_taken && (bus.branch_target[1:0] == 2'b00);
    assign tgt      = bus.branch_target;
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_q <= 1'b0;
        else if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end
`else
    assign redirect = bus.branch_taken;
    assign tgt      = bus.branch_target & ~ADDR_W'(3);
    assign bus.misalign_err = 1'b0;
`endif

    assign head_valid    = (count != '0);
    assign push          = (state == FETCH) && bus.imem_ack && !redirect;
    assign pop           = head_valid && !bus.stall && !redirect;
    assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
    assign fetch_pc_next = redirect ? tgt : (push ? fetch_pc + ADDR_W'(4) : fetch_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (redirect || (count < DEPTH)) state_next = FETCH;
            FETCH: begin
                if (bus.imem_ack)
                    state_next = (redirect || (count_next < DEPTH)) ? FETCH : IDLE;
                else if (redirect)
                    state_next = DROP;
            end
            DROP:  if (bus.imem_ack) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req  = (state != IDLE);
        bus.imem_addr = addr_q;
    end

    // The request address is frozen while a wrong-path request drains in DROP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_next;
            if (state_next != DROP)
                addr_q <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

    always_comb begin
        bus.instr_valid = head_valid;
        bus.instr       = head_valid ? buf_instr[rd_ptr] : 32'h0;
        bus.instr_pc    = head_valid ? buf_pc[rd_ptr] : '0;
        bus.opcode      = bus.instr[6:0];
    end
endmodule
